// File: rtl/key_pkg.sv
// Shared definitions for the key-handling blocks: click FSM states and window sizing.
package key_pkg;

    typedef enum logic {IDLE, WAIT} click_state_t;

    // Converts a window length in microseconds into clock cycles.
    function automatic int unsigned win_cycles(input int unsigned freq_mhz,
                                               input int unsigned window_us);
        return freq_mhz * window_us;
    endfunction

endpackage

// File: rtl/window_timer.sv
// Cycle counter that restarts on demand and flags the last cycle of a WIN-cycle window.
module window_timer #(
    parameter int unsigned WIN = 5
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic restart_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned TW = (WIN > 1) ? $clog2(WIN) : 1;

    logic [TW-1:0] timer;

    assign expired_o = (timer == TW'(WIN - 1));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            timer <= '0;
        end else if (restart_i) begin
            timer <= '0;
        end else if (run_i) begin
            timer <= expired_o ? '0 : timer + TW'(1);
        end
    end

endmodule

// File: rtl/multi_click_detector.sv
// Groups debounced key presses separated by less than the click window into one counted click event.
module multi_click_detector
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ    = 100,
    parameter int unsigned CLICK_WINDOW_US = 250000,
    parameter int unsigned MAX_CLICKS      = 3,
    localparam int unsigned CNT_W          = $clog2(MAX_CLICKS + 1)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             key_pressed_stb_i,
    output logic             click_valid_o,
    output logic [CNT_W-1:0] click_count_o,
    output logic             busy_o
);

    localparam int unsigned WIN = win_cycles(CLK_FREQ_MHZ, CLICK_WINDOW_US);

    if (WIN < 2) begin : g_bad_win
        $error("multi_click_detector: click window must span at least 2 cycles");
    end
    if (MAX_CLICKS < 2) begin : g_bad_max
        $error("multi_click_detector: MAX_CLICKS must be at least 2");
    end

    click_state_t     state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W-1:0] click_count_next;
    logic             valid_next;
    logic             restart;
    logic             expired;

    window_timer #(
        .WIN(WIN)
    ) u_window_timer (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .restart_i(restart),
        .run_i    (state == WAIT),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state         <= IDLE;
            count         <= '0;
            click_valid_o <= 1'b0;
            click_count_o <= '0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            click_valid_o <= valid_next;
            click_count_o <= click_count_next;
        end
    end

    // A press always takes priority over the timeout, so it restarts the window instead of closing the group.
    always_comb begin
        state_next       = state;
        count_next       = count;
        valid_next       = 1'b0;
        click_count_next = click_count_o;
        restart          = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_pressed_stb_i) begin
                    count_next = CNT_W'(1);
                    restart    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (key_pressed_stb_i) begin
                    count_next = count + CNT_W'(1);
                    restart    = 1'b1;
                    if (count_next == CNT_W'(MAX_CLICKS)) begin
                        valid_next       = 1'b1;
                        click_count_next = CNT_W'(MAX_CLICKS);
                        state_next       = IDLE;
                    end
                end else if (expired) begin
                    valid_next       = 1'b1;
                    click_count_next = count;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_o = (state == WAIT);

endmodule

// File: tb/tb_multi_click_detector.sv
// Self-checking bench: directed test-plan scenarios plus random press/reset traffic against a press-time model.
module tb_multi_click_detector;

    localparam int unsigned FREQ  = 1;
    localparam int unsigned WUS   = 5;
    localparam int unsigned MAXC  = 3;
    localparam int unsigned WIN   = FREQ * WUS;
    localparam int unsigned CNT_W = $clog2(MAXC + 1);

    logic             clk = 1'b0;
    logic             srst = 1'b0;
    logic             strobe = 1'b0;
    logic             click_valid;
    logic [CNT_W-1:0] click_count;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // Reference model: a group is described by its press count and the time of its latest press.
    bit m_open = 1'b0;
    int m_n    = 0;
    int m_last = 0;
    int m_edge = 0;
    bit m_valid = 1'b0;
    int m_count = 0;

    multi_click_detector #(
        .CLK_FREQ_MHZ   (FREQ),
        .CLICK_WINDOW_US(WUS),
        .MAX_CLICKS     (MAXC)
    ) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .key_pressed_stb_i(strobe),
        .click_valid_o    (click_valid),
        .click_count_o    (click_count),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit s, input bit r);
        m_edge++;
        m_valid = 1'b0;
        if (r) begin
            m_open  = 1'b0;
            m_n     = 0;
            m_count = 0;
        end else if (s) begin
            m_last = m_edge;
            if (!m_open) begin
                m_open = 1'b1;
                m_n    = 1;
            end else begin
                m_n++;
                if (m_n == MAXC) begin
                    m_valid = 1'b1;
                    m_count = m_n;
                    m_open  = 1'b0;
                end
            end
        end else if (m_open && (m_edge - m_last == WIN)) begin
            m_valid = 1'b1;
            m_count = m_n;
            m_open  = 1'b0;
        end
    endtask

    task automatic tick(input bit s, input bit r);
        @(negedge clk);
        strobe = s;
        srst   = r;
        @(posedge clk);
        model_edge(s, r);
        #1;
        check("valid", 32'(click_valid), 32'(m_valid));
        check("count", 32'(click_count), 32'(m_count));
        check("busy",  32'(busy),        32'(m_open));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("reset_valid", 32'(click_valid), 32'd0);
        check("reset_count", 32'(click_count), 32'd0);
        check("reset_busy",  32'(busy),        32'd0);
        idle(3);

        // Single press: emits WIN edges after the press with count 1.
        tick(1'b1, 1'b0);
        check("single_busy", 32'(busy), 32'd1);
        idle(4);
        check("single_early", 32'(click_valid), 32'd0);
        idle(1);
        check("single_valid", 32'(click_valid), 32'd1);
        check("single_count", 32'(click_count), 32'd1);
        check("single_idle",  32'(busy),        32'd0);
        idle(3);
        check("single_held", 32'(click_count), 32'd1);

        // Double press with gap of 3.
        tick(1'b1, 1'b0);
        idle(2);
        tick(1'b1, 1'b0);
        idle(5);
        check("double_valid", 32'(click_valid), 32'd1);
        check("double_count", 32'(click_count), 32'd2);
        idle(3);

        // Max clicks closes immediately; next press opens a new group.
        tick(1'b1, 1'b0);
        idle(1);
        tick(1'b1, 1'b0);
        idle(1);
        tick(1'b1, 1'b0);
        check("max_valid", 32'(click_valid), 32'd1);
        check("max_count", 32'(click_count), 32'd3);
        check("max_busy",  32'(busy),        32'd0);
        tick(1'b1, 1'b0);
        check("after_max_busy", 32'(busy), 32'd1);
        idle(5);
        check("after_max_count", 32'(click_count), 32'd1);
        check("after_max_valid", 32'(click_valid), 32'd1);
        idle(3);

        // Press on the timeout edge wins over the emission.
        tick(1'b1, 1'b0);
        idle(4);
        tick(1'b1, 1'b0);
        check("tie_no_valid", 32'(click_valid), 32'd0);
        idle(5);
        check("tie_count", 32'(click_count), 32'd2);
        idle(3);

        // Back-to-back presses.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        idle(5);
        check("b2b_valid", 32'(click_valid), 32'd1);
        check("b2b_count", 32'(click_count), 32'd2);
        idle(3);

        // Reset mid-group drops the group; a strobe during reset is ignored.
        tick(1'b1, 1'b0);
        idle(1);
        tick(1'b1, 1'b1);
        check("rst_count", 32'(click_count), 32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        idle(18);
        check("rst_quiet", 32'(click_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) s = 1'b1;
            tick(s, r);
        end
        idle(WIN + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
